// File: rtl/program_loader.sv
// program_loader: streams a program into instruction memory, then runs the core.
// Ports: clk, rst_n | start/prog_len | src_* | imem_* | cpu_rst_n/cpu_instr | status.
module program_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFEFEFEFE,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  src_valid,
    input  logic [31:0]           src_data,
    output logic                  src_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst_n,
    input  logic [31:0]           cpu_instr,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [31:0]           cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        TMO
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [31:0]         TMO_LAST = 32'(TIMEOUT - 1);

    state_t                state;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  start_ok;
    logic                  last_word;

    assign start_ok  = start && (prog_len != '0) && (prog_len <= MAX_LEN);
    // idx never exceeds len-1, so comparing idx+1 against len finds the final word
    assign last_word = (({1'b0, idx} + 1'b1) == len);

    assign src_ready = (state == LOAD);
    assign busy      = (state == LOAD) || (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len         <= '0;
            idx         <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_rst_n   <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE, DONE, TMO: begin
                    if (start_ok) begin
                        state       <= LOAD;
                        len         <= prog_len;
                        idx         <= '0;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                    end
                end
                LOAD: begin
                    if (src_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= idx;
                        imem_wdata <= src_data;
                        idx        <= idx + 1'b1;
                        if (last_word) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // First RUN cycle carries the last write; release core after it
                    if (!cpu_rst_n) begin
                        cpu_rst_n <= 1'b1;
                    end else begin
                        if (cycle_count != '1) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                        if (cpu_instr == HALT_WORD) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b0;
                        end else if (cycle_count == TMO_LAST) begin
                            state     <= TMO;
                            timeout   <= 1'b1;
                            cpu_rst_n <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed load/run sequences for program_loader.
// Expected imem writes go through a queue; status outputs checked per step.
module tb_program_loader;

    localparam int          AW   = 8;
    localparam logic [31:0] HALT = 32'hFEFEFEFE;
    localparam int          TMO  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   prog_len;
    logic          src_valid;
    logic [31:0]   src_data;
    logic          src_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic [31:0]   cpu_instr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [31:0]   cycle_count;

    program_loader #(
        .ADDR_WIDTH(AW),
        .HALT_WORD (HALT),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .prog_len   (prog_len),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_instr  (cpu_instr),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          nwr    = 0;
    logic [31:0] prog [3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, score any imem write
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            nwr++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_write: observed addr=%h data=%h expected none",
                       imem_addr, imem_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    endtask

    task automatic load3(input int gap);
        nwr      = 0;
        prog_len = 9'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", 32'(busy), 1);
        chk("load_ready", 32'(src_ready), 1);
        chk("load_done_clr", 32'(done), 0);
        chk("load_tmo_clr", 32'(timeout), 0);
        chk("load_cnt_clr", cycle_count, 0);
        for (int i = 0; i < 3; i++) begin
            src_valid = 1'b1;
            src_data  = prog[i];
            exp_q.push_back('{addr: AW'(i), data: prog[i]});
            tick();
            src_valid = 1'b0;
            src_data  = $urandom;
            if (i < 2) begin
                repeat (gap) tick();
            end
        end
        chk("run1_cpu_rst", 32'(cpu_rst_n), 0);
        chk("run1_ready", 32'(src_ready), 0);
        chk("run1_busy", 32'(busy), 1);
        // Offer a stray word; it must not be accepted
        src_valid = 1'b1;
        src_data  = $urandom;
        tick();
        src_valid = 1'b0;
        chk("cpu_release", 32'(cpu_rst_n), 1);
        chk("write_count", 32'(nwr), 3);
        chk("queue_empty", 32'(exp_q.size()), 0);
    endtask

    // Run cycles 1..last out of reset; halt sentinel on cycle last if requested
    task automatic run(input int last, input bit halt, input bit poke);
        for (int k = 1; k <= last; k++) begin
            cpu_instr = (halt && k == last) ? HALT : 32'(k);
            if (poke && k == 2) begin
                start    = 1'b1;
                prog_len = 9'd2;
            end
            tick();
            start = 1'b0;
            chk("run_cnt", cycle_count, 32'(k));
            if (k < last) begin
                chk("run_cpu_rst", 32'(cpu_rst_n), 1);
                chk("run_busy", 32'(busy), 1);
                chk("run_ready", 32'(src_ready), 0);
            end
        end
        cpu_instr = 32'h0;
    endtask

    initial begin
        prog[0]   = 32'h20080005;
        prog[1]   = 32'h2009000A;
        prog[2]   = HALT;
        rst_n     = 1'b0;
        start     = 1'b0;
        prog_len  = '0;
        src_valid = 1'b0;
        src_data  = '0;
        cpu_instr = '0;

        repeat (2) tick();
        chk("rst_ready", 32'(src_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", 32'(cpu_rst_n), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tmo", 32'(timeout), 0);
        chk("rst_cnt", cycle_count, 0);
        rst_n = 1'b1;
        tick();

        // Zero and oversize lengths are ignored
        prog_len = 9'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_busy", 32'(busy), 0);
        chk("len0_ready", 32'(src_ready), 0);
        prog_len = 9'd257;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("len257_busy", 32'(busy), 0);

        // Back-to-back load, halt on cycle 5, start poked mid-run
        load3(0);
        run(5, 1'b1, 1'b1);
        chk("halt_done", 32'(done), 1);
        chk("halt_tmo", 32'(timeout), 0);
        chk("halt_cpu_rst", 32'(cpu_rst_n), 0);
        chk("halt_busy", 32'(busy), 0);
        tick();
        chk("halt_sticky", 32'(done), 1);
        chk("halt_cnt_frozen", cycle_count, 5);

        // Gapped load, watchdog fires
        load3(2);
        run(TMO, 1'b0, 1'b0);
        chk("wd_tmo", 32'(timeout), 1);
        chk("wd_done", 32'(done), 0);
        chk("wd_cpu_rst", 32'(cpu_rst_n), 0);
        tick();
        chk("wd_cnt_frozen", cycle_count, 32'(TMO));

        prog_len = 9'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo_len0_busy", 32'(busy), 0);
        chk("tmo_len0_sticky", 32'(timeout), 1);

        // Halt on the watchdog cycle: halt wins
        load3(0);
        run(TMO, 1'b1, 1'b0);
        chk("tie_done", 32'(done), 1);
        chk("tie_tmo", 32'(timeout), 0);

        // Async reset mid-run
        load3(1);
        run(3, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_cpu_rst", 32'(cpu_rst_n), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_tmo", 32'(timeout), 0);
        chk("arst_cnt", cycle_count, 0);
        chk("arst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
